ysyx_25020037_lsu: RTL

Load/store stage of the ysyx_25020037 multi-cycle core, directly downstream of the execute stage and upstream of write-back. It captures one execute result per handshake, performs at most one AXI4-Lite data access (aligned, byte/half/word), and forwards the write-back bundle to the write-back stage. Non-memory instructions pass through in one cycle.

---
 rtl/ysyx_25020037_lsu_pkg.sv | 56 +++++
 rtl/ysyx_25020037_lsu_align.sv | 46 ++++
 rtl/ysyx_25020037_lsu.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/ysyx_25020037_lsu_pkg.sv
// Shared widths, bundle layouts, memory-size encodings and LSU state encoding.
// Imported by the LSU top and its alignment helper.
package ysyx_25020037_lsu_pkg;

  localparam int DU_TO_GU_BUS_WD = 16;
  localparam int DU_TO_WU_BUS_WD = 8;
  localparam int DU_TO_LU_BUS_WD = 5;
  localparam int EU_TO_LU_BUS_WD = DU_TO_GU_BUS_WD + DU_TO_LU_BUS_WD + DU_TO_WU_BUS_WD + 96;
  localparam int LU_TO_WU_BUS_WD = DU_TO_GU_BUS_WD + DU_TO_WU_BUS_WD + 64;

  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;

  typedef enum logic [2:0] {
    LSU_IDLE = 3'd0,
    LSU_AR   = 3'd1,
    LSU_R    = 3'd2,
    LSU_AW_W = 3'd3,
    LSU_B    = 3'd4,
    LSU_OUT  = 3'd5
  } lsu_state_e;

  typedef struct packed {
    logic       ren;
    logic       wen;
    logic [1:0] size;
    logic       is_unsigned;
  } lu_ctrl_t;

  typedef struct packed {
    logic [DU_TO_GU_BUS_WD-1:0] gu;
    lu_ctrl_t                   ctrl;
    logic [DU_TO_WU_BUS_WD-1:0] wu;
    logic [31:0]                csr_wdata;
    logic [31:0]                result;
    logic [31:0]                store_data;
  } eu_to_lu_t;

  typedef struct packed {
    logic [DU_TO_GU_BUS_WD-1:0] gu;
    logic [DU_TO_WU_BUS_WD-1:0] wu;
    logic [31:0]                csr_wdata;
    logic [31:0]                wb_data;
  } lu_to_wu_t;

  // Bytes are never misaligned; any unknown size is held to word alignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      MEM_SIZE_B: return 1'b0;
      MEM_SIZE_H: return addr_lo[0];
      default:    return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_25020037_lsu_align.sv
// Byte-lane steering: store strobe/data placement and load extraction with sign/zero extension.
// Purely combinational.
module ysyx_25020037_lsu_align
  import ysyx_25020037_lsu_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  logic [4:0]  shamt;
  logic [3:0]  strb_base;
  logic [31:0] rd_shifted;

  assign shamt = {addr_lo_i, 3'b000};

  always_comb begin
    strb_base = 4'b1111;
    case (size_i)
      MEM_SIZE_B: strb_base = 4'b0001;
      MEM_SIZE_H: strb_base = 4'b0011;
      default:    strb_base = 4'b1111;
    endcase
  end

  assign wstrb_o    = strb_base << addr_lo_i;
  assign wdata_o    = store_data_i << shamt;
  assign rd_shifted = rdata_i >> shamt;

  always_comb begin
    load_data_o = rd_shifted;
    case (size_i)
      MEM_SIZE_B: load_data_o = unsigned_i ? {24'd0, rd_shifted[7:0]}
                                           : {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      MEM_SIZE_H: load_data_o = unsigned_i ? {16'd0, rd_shifted[15:0]}
                                           : {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      default:    load_data_o = rd_shifted;
    endcase
  end

endmodule

// File: rtl/ysyx_25020037_lsu.sv
// Load/store stage: captures one execute result, performs at most one AXI4-Lite access,
// and holds the write-back bundle until write-back accepts it.
module ysyx_25020037_lsu
  import ysyx_25020037_lsu_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       exu_valid,
  output logic                       lsu_ready,
  input  logic [EU_TO_LU_BUS_WD-1:0] eu_to_lu_bus,
  input  logic                       wbu_ready,
  output logic                       lsu_valid,
  output logic [LU_TO_WU_BUS_WD-1:0] lu_to_wu_bus,
  output logic                       lsu_fault,
  output logic [31:0]                araddr,
  output logic                       arvalid,
  input  logic                       arready,
  input  logic [31:0]                rdata,
  input  logic [1:0]                 rresp,
  input  logic                       rvalid,
  output logic                       rready,
  output logic [31:0]                awaddr,
  output logic                       awvalid,
  input  logic                       awready,
  output logic [31:0]                wdata,
  output logic [3:0]                 wstrb,
  output logic                       wvalid,
  input  logic                       wready,
  input  logic [1:0]                 bresp,
  input  logic                       bvalid,
  output logic                       bready
);

  eu_to_lu_t  in_bus, req_q, req_d;
  lu_to_wu_t  out_bus;
  lsu_state_e state_q, state_d;

  logic [31:0] wb_data_q, wb_data_d;
  logic        fault_q, fault_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;

  logic        accept, in_mem, in_mis, aw_hs, w_hs;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata, al_load;

  assign in_bus = eu_to_lu_t'(eu_to_lu_bus);
  assign accept = exu_valid & lsu_ready;
  assign in_mem = in_bus.ctrl.ren | in_bus.ctrl.wen;
  assign in_mis = in_mem & is_misaligned(in_bus.ctrl.size, in_bus.result[1:0]);
  assign aw_hs  = awvalid & awready;
  assign w_hs   = wvalid & wready;

  ysyx_25020037_lsu_align u_align (
    .addr_lo_i    (req_q.result[1:0]),
    .size_i       (req_q.ctrl.size),
    .unsigned_i   (req_q.ctrl.is_unsigned),
    .store_data_i (req_q.store_data),
    .rdata_i      (rdata),
    .wstrb_o      (al_wstrb),
    .wdata_o      (al_wdata),
    .load_data_o  (al_load)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= LSU_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE: begin
        if (accept) begin
          // A load wins when both ren and wen are set.
          if (!in_mem || in_mis)    state_d = LSU_OUT;
          else if (in_bus.ctrl.ren) state_d = LSU_AR;
          else                      state_d = LSU_AW_W;
        end
      end
      LSU_AR:   if (arready) state_d = LSU_R;
      LSU_R:    if (rvalid)  state_d = LSU_OUT;
      LSU_AW_W: if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) state_d = LSU_B;
      LSU_B:    if (bvalid)    state_d = LSU_OUT;
      LSU_OUT:  if (wbu_ready) state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  // Handshake outputs decode only registered state, never the AXI inputs.
  always_comb begin
    lsu_ready = 1'b0;
    lsu_valid = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    case (state_q)
      LSU_IDLE: lsu_ready = 1'b1;
      LSU_AR:   arvalid   = 1'b1;
      LSU_R:    rready    = 1'b1;
      LSU_AW_W: begin
        awvalid = ~aw_done_q;
        wvalid  = ~w_done_q;
      end
      LSU_B:    bready    = 1'b1;
      LSU_OUT:  lsu_valid = 1'b1;
      default:  ;
    endcase
  end

  always_comb begin
    req_d     = req_q;
    wb_data_d = wb_data_q;
    fault_d   = fault_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      LSU_IDLE: begin
        if (accept) begin
          req_d     = in_bus;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          fault_d   = in_mis;
          wb_data_d = in_mem ? 32'd0 : in_bus.result;
        end
      end
      LSU_R: begin
        if (rvalid) begin
          wb_data_d = al_load;
          fault_d   = rresp != 2'b00;
        end
      end
      LSU_AW_W: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
      end
      LSU_B: if (bvalid) fault_d = bresp != 2'b00;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q     <= '0;
      wb_data_q <= 32'd0;
      fault_q   <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      req_q     <= req_d;
      wb_data_q <= wb_data_d;
      fault_q   <= fault_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    out_bus.gu        = req_q.gu;
    out_bus.wu        = req_q.wu;
    out_bus.csr_wdata = req_q.csr_wdata;
    out_bus.wb_data   = wb_data_q;
  end

  assign lu_to_wu_bus = out_bus;
  assign lsu_fault    = lsu_valid & fault_q;
  assign araddr       = arvalid ? {req_q.result[31:2], 2'b00} : 32'd0;
  assign awaddr       = awvalid ? {req_q.result[31:2], 2'b00} : 32'd0;
  assign wdata        = wvalid ? al_wdata : 32'd0;
  assign wstrb        = wvalid ? al_wstrb : 4'd0;

endmodule
